// File: rtl/ps2_bk_keyboard_if.sv
// CPU-side register bus of the BK keyboard controller.
// This is a VM1-style strobe/reply cycle: the master drives address and strobe, and the slave answers with ack and data.
interface ps2_bk_keyboard_if;
    logic        bus_sync;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_wtbt;
    logic        bus_stb;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        bus_ack;

    modport master (
        output bus_sync, bus_addr, bus_we, bus_wtbt, bus_stb, bus_din,
        input  bus_dout, bus_ack
    );

    modport slave (
        input  bus_sync, bus_addr, bus_we, bus_wtbt, bus_stb, bus_din,
        output bus_dout, bus_ack
    );
endinterface

// File: rtl/ps2_bk_keyboard.sv
// PS/2-to-BK keyboard controller: translates key events to 7-bit codes and queues them in a small FIFO.
// It also exposes registers 177660/177662 on the VM1 bus and raises vector 060/274 requests.
module ps2_bk_keyboard #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] STOP_SCAN  = 8'h78,
    parameter logic [7:0] RESET_SCAN = 8'h07
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    ps2_bk_keyboard_if.slave bus,
    output logic             virq_req60,
    output logic             virq_req274,
    input  logic             virq_ack60,
    input  logic             virq_ack274,
    output logic             key_down,
    output logic             key_stop,
    output logic             key_reset,
    output logic             key_color,
    output logic             key_bw,
    output logic             ps2_caps_led
);

    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [14:0] STAT_WA = 15'o77730;
    localparam logic [14:0] DATA_WA = 15'o77731;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? v : v - 3'd1;
    endfunction

    // Returns {hit, lower-case code}; hit = 0 for keys with no BK code.
    function automatic logic [7:0] xlate(input logic ext, input logic [7:0] sc);
        logic [7:0] r;
        r = 8'h00;
        if (ext) begin
            case (sc)
                8'h6B:   r = {1'b1, 7'h08};
                8'h74:   r = {1'b1, 7'h19};
                8'h75:   r = {1'b1, 7'h1A};
                8'h72:   r = {1'b1, 7'h1B};
                default: r = 8'h00;
            endcase
        end else begin
            case (sc)
                8'h1C: r = {1'b1, 7'h61};  8'h32: r = {1'b1, 7'h62};
                8'h21: r = {1'b1, 7'h63};  8'h23: r = {1'b1, 7'h64};
                8'h24: r = {1'b1, 7'h65};  8'h2B: r = {1'b1, 7'h66};
                8'h34: r = {1'b1, 7'h67};  8'h33: r = {1'b1, 7'h68};
                8'h43: r = {1'b1, 7'h69};  8'h3B: r = {1'b1, 7'h6A};
                8'h42: r = {1'b1, 7'h6B};  8'h4B: r = {1'b1, 7'h6C};
                8'h3A: r = {1'b1, 7'h6D};  8'h31: r = {1'b1, 7'h6E};
                8'h44: r = {1'b1, 7'h6F};  8'h4D: r = {1'b1, 7'h70};
                8'h15: r = {1'b1, 7'h71};  8'h2D: r = {1'b1, 7'h72};
                8'h1B: r = {1'b1, 7'h73};  8'h2C: r = {1'b1, 7'h74};
                8'h3C: r = {1'b1, 7'h75};  8'h2A: r = {1'b1, 7'h76};
                8'h1D: r = {1'b1, 7'h77};  8'h22: r = {1'b1, 7'h78};
                8'h35: r = {1'b1, 7'h79};  8'h1A: r = {1'b1, 7'h7A};
                8'h16: r = {1'b1, 7'h31};  8'h1E: r = {1'b1, 7'h32};
                8'h26: r = {1'b1, 7'h33};  8'h25: r = {1'b1, 7'h34};
                8'h2E: r = {1'b1, 7'h35};  8'h36: r = {1'b1, 7'h36};
                8'h3D: r = {1'b1, 7'h37};  8'h3E: r = {1'b1, 7'h38};
                8'h46: r = {1'b1, 7'h39};  8'h45: r = {1'b1, 7'h30};
                8'h29: r = {1'b1, 7'h20};  8'h5A: r = {1'b1, 7'h0A};
                8'h66: r = {1'b1, 7'h18};  8'h0D: r = {1'b1, 7'h09};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    function automatic logic [6:0] shape_code(input logic [6:0] c, input logic upper,
                                              input logic ctrl);
        logic [6:0] r;
        r = c;
        if (upper && c >= 7'h61 && c <= 7'h7A) r[5] = 1'b0;
        if (ctrl) r = r & 7'h1F;
        return r;
    endfunction

    // ---- stage p0: event detect and modifier/held-key state ----
    logic       strobe_q;
    logic       evt_p0, pressed_p0, ext_p0;
    logic [7:0] scan_p0, xl_p0;
    logic       is_shift, is_ctrl, is_alt, is_caps, is_mod;
    logic       shift_q, ctrl_q, alt_q, caps_q;
    logic [2:0] held;

    assign evt_p0     = ps2_key[10] ^ strobe_q;
    assign pressed_p0 = ps2_key[9];
    assign ext_p0     = ps2_key[8];
    assign scan_p0    = ps2_key[7:0];
    assign xl_p0      = xlate(ext_p0, scan_p0);

    assign is_shift = (scan_p0 == 8'h12) || (scan_p0 == 8'h59);
    assign is_ctrl  = (scan_p0 == 8'h14);
    assign is_alt   = (scan_p0 == 8'h11);
    assign is_caps  = (scan_p0 == 8'h58);
    assign is_mod   = is_shift | is_ctrl | is_alt | is_caps;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strobe_q  <= ps2_key[10];
            shift_q   <= 1'b0;
            ctrl_q    <= 1'b0;
            alt_q     <= 1'b0;
            caps_q    <= 1'b0;
            held      <= 3'd0;
            key_stop  <= 1'b0;
            key_reset <= 1'b0;
            key_color <= 1'b0;
            key_bw    <= 1'b0;
        end else begin
            strobe_q  <= ps2_key[10];
            key_color <= evt_p0 & pressed_p0 & (scan_p0 == 8'h01);
            key_bw    <= evt_p0 & pressed_p0 & (scan_p0 == 8'h09);
            if (evt_p0) begin
                if (is_shift)              shift_q   <= pressed_p0;
                if (is_ctrl)               ctrl_q    <= pressed_p0;
                if (is_alt)                alt_q     <= pressed_p0;
                if (is_caps && pressed_p0) caps_q    <= ~caps_q;
                if (scan_p0 == STOP_SCAN)  key_stop  <= pressed_p0;
                if (scan_p0 == RESET_SCAN) key_reset <= pressed_p0;
                if (!is_mod)               held      <= pressed_p0 ? sat_inc(held) : sat_dec(held);
            end
        end
    end

    assign key_down     = (held != 3'd0);
    assign ps2_caps_led = caps_q;

    // ---- stage p1: registered translation, pushed into the FIFO next edge ----
    logic       vld_p1;
    logic [6:0] code_p1;
    logic       ar2_p1;

    always_ff @(posedge clk_sys) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= evt_p0 & pressed_p0 & ~is_mod & xl_p0[7];
    end

    always_ff @(posedge clk_sys) begin
        code_p1 <= shape_code(xl_p0[6:0], shift_q ^ caps_q, ctrl_q);
        ar2_p1  <= alt_q;
    end

    // ---- code FIFO ----
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, full, push, pop;
    logic [7:0]    head;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign push  = vld_p1 & ~full;
    assign head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr] <= {ar2_p1, code_p1};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- register bus: one reply per strobe rise, held until the strobe drops ----
    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;

    bus_state_t  bus_state, bus_state_nx;
    logic        stb_q, stb_rise, sel_stat, sel_data, start;
    logic        irq_dis, pend_taken, req;
    logic [15:0] rd_val, dout_q, dout_nx;

    assign sel_stat = bus.bus_sync & (bus.bus_addr[15:1] == STAT_WA);
    assign sel_data = bus.bus_sync & (bus.bus_addr[15:1] == DATA_WA);
    assign stb_rise = bus.bus_stb & ~stb_q;
    assign start    = stb_rise & (sel_stat | sel_data) & (bus_state == BUS_IDLE);
    assign pop      = start & sel_data & ~bus.bus_we & ~empty;
    assign rd_val   = sel_data ? (empty ? 16'h0000 : {9'b0, head[6:0]})
                               : {8'b0, ~empty, irq_dis, 6'b0};

    always_comb begin
        bus_state_nx = bus_state;
        dout_nx      = dout_q;
        case (bus_state)
            BUS_IDLE: if (start) begin
                bus_state_nx = BUS_ACK;
                dout_nx      = bus.bus_we ? 16'h0000 : rd_val;
            end
            BUS_ACK: if (!bus.bus_stb) begin
                bus_state_nx = BUS_IDLE;
                dout_nx      = 16'h0000;
            end
            default: begin
                bus_state_nx = BUS_IDLE;
                dout_nx      = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus_state <= BUS_IDLE;
            dout_q    <= 16'h0000;
            stb_q     <= bus.bus_stb;
        end else begin
            bus_state <= bus_state_nx;
            dout_q    <= dout_nx;
            stb_q     <= bus.bus_stb;
        end
    end

    assign bus.bus_ack  = (bus_state == BUS_ACK);
    assign bus.bus_dout = dout_q;

    // ---- interrupt requests, routed by the AR2 flag of the head entry ----
    assign req = ~empty & ~irq_dis & ~pend_taken;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            irq_dis     <= 1'b0;
            pend_taken  <= 1'b0;
            virq_req60  <= 1'b0;
            virq_req274 <= 1'b0;
        end else begin
            if (start && sel_stat && bus.bus_we && bus.bus_wtbt[0]) irq_dis <= bus.bus_din[6];
            if (pop)                             pend_taken <= 1'b0;
            else if (virq_ack60 || virq_ack274)  pend_taken <= 1'b1;
            virq_req60  <= req & ~head[7];
            virq_req274 <= req &  head[7];
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.bus_addr[0], bus.bus_wtbt[1],
                           bus.bus_din[15:7], bus.bus_din[5:0]};

endmodule

// File: tb/tb_ps2_bk_keyboard.sv
// Directed bench for ps2_bk_keyboard: key events, FIFO, register bus, interrupts and reset.
module tb_ps2_bk_keyboard;
    localparam logic [15:0] STAT = 16'o177660;
    localparam logic [15:0] DATA = 16'o177662;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        virq_req60, virq_req274, virq_ack60, virq_ack274;
    logic        key_down, key_stop, key_reset, key_color, key_bw, ps2_caps_led;
    int          checks = 0;
    int          errors = 0;

    ps2_bk_keyboard_if bus ();

    ps2_bk_keyboard dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .bus          (bus),
        .virq_req60   (virq_req60),
        .virq_req274  (virq_req274),
        .virq_ack60   (virq_ack60),
        .virq_ack274  (virq_ack274),
        .key_down     (key_down),
        .key_stop     (key_stop),
        .key_reset    (key_reset),
        .key_color    (key_color),
        .key_bw       (key_bw),
        .ps2_caps_led (ps2_caps_led)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic ext, input logic [7:0] sc, input logic pr);
        ps2_key = {~ps2_key[10], pr, ext, sc};
        repeat (3) tick();
    endtask

    task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [1:0] wtbt,
                             input logic [15:0] din, output logic [15:0] rdata,
                             output logic acked);
        bus.bus_sync = 1'b1;
        bus.bus_addr = addr;
        bus.bus_we   = we;
        bus.bus_wtbt = wtbt;
        bus.bus_din  = din;
        bus.bus_stb  = 1'b1;
        acked = 1'b0;
        rdata = 16'hDEAD;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (bus.bus_ack) begin
                acked = 1'b1;
                rdata = bus.bus_dout;
            end
        end
        bus.bus_stb  = 1'b0;
        bus.bus_sync = 1'b0;
        bus.bus_we   = 1'b0;
        tick();
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        logic        a;
        bus_cycle(addr, 1'b0, 2'b00, 16'h0000, d, a);
        check({tag, "_ack"}, {15'b0, a}, 16'h0001);
        check(tag, d, exp);
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [1:0] wtbt,
                      input logic [15:0] din);
        logic [15:0] d;
        logic        a;
        bus_cycle(addr, 1'b1, wtbt, din, d, a);
        check({tag, "_ack"}, {15'b0, a}, 16'h0001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        ps2_key      = 11'h000;
        virq_ack60   = 1'b0;
        virq_ack274  = 1'b0;
        bus.bus_sync = 1'b0;
        bus.bus_addr = 16'h0000;
        bus.bus_we   = 1'b0;
        bus.bus_wtbt = 2'b00;
        bus.bus_stb  = 1'b0;
        bus.bus_din  = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_req60", {15'b0, virq_req60}, 16'h0000);
        check("rst_req274", {15'b0, virq_req274}, 16'h0000);
        check("rst_key_down", {15'b0, key_down}, 16'h0000);
        check("rst_caps", {15'b0, ps2_caps_led}, 16'h0000);
        check("rst_ack", {15'b0, bus.bus_ack}, 16'h0000);
        rd("rst_status", STAT, 16'h0000);
        rd("rst_data", DATA, 16'h0000);

        // Plain 'a'
        key(1'b0, 8'h1C, 1'b1);
        check("a_req60", {15'b0, virq_req60}, 16'h0001);
        check("a_key_down", {15'b0, key_down}, 16'h0001);
        rd("a_status", STAT, 16'h0080);
        rd("a_data", DATA, 16'h0061);
        rd("a_status_after", STAT, 16'h0000);
        check("a_req60_drop", {15'b0, virq_req60}, 16'h0000);
        key(1'b0, 8'h1C, 1'b0);
        check("a_key_up", {15'b0, key_down}, 16'h0000);

        // Shift+A
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h1C, 1'b1);
        key(1'b0, 8'h1C, 1'b0);
        key(1'b0, 8'h12, 1'b0);
        rd("shift_a", DATA, 16'h0041);

        // Caps on, Shift+A gives lower case
        key(1'b0, 8'h58, 1'b1);
        key(1'b0, 8'h58, 1'b0);
        check("caps_led_on", {15'b0, ps2_caps_led}, 16'h0001);
        key(1'b0, 8'h12, 1'b1);
        key(1'b0, 8'h1C, 1'b1);
        key(1'b0, 8'h1C, 1'b0);
        key(1'b0, 8'h12, 1'b0);
        rd("caps_shift_a", DATA, 16'h0061);
        key(1'b0, 8'h58, 1'b1);
        key(1'b0, 8'h58, 1'b0);
        check("caps_led_off", {15'b0, ps2_caps_led}, 16'h0000);

        // Ctrl+A
        key(1'b0, 8'h14, 1'b1);
        key(1'b0, 8'h1C, 1'b1);
        key(1'b0, 8'h1C, 1'b0);
        key(1'b0, 8'h14, 1'b0);
        rd("ctrl_a", DATA, 16'h0001);

        // Alt+Enter goes to vector 274
        key(1'b0, 8'h11, 1'b1);
        key(1'b0, 8'h5A, 1'b1);
        check("alt_req274", {15'b0, virq_req274}, 16'h0001);
        check("alt_req60", {15'b0, virq_req60}, 16'h0000);
        rd("alt_enter", DATA, 16'h000A);
        key(1'b0, 8'h5A, 1'b0);
        key(1'b0, 8'h11, 1'b0);

        // Extended arrow and a digit
        key(1'b1, 8'h75, 1'b1);
        key(1'b1, 8'h75, 1'b0);
        rd("arrow_up", DATA, 16'h001A);
        key(1'b0, 8'h45, 1'b1);
        key(1'b0, 8'h45, 1'b0);
        rd("digit_0", DATA, 16'h0030);

        // Overflow: a..f held, only a..d kept
        key(1'b0, 8'h1C, 1'b1);
        key(1'b0, 8'h32, 1'b1);
        key(1'b0, 8'h21, 1'b1);
        key(1'b0, 8'h23, 1'b1);
        key(1'b0, 8'h24, 1'b1);
        key(1'b0, 8'h2B, 1'b1);
        rd("ovf_0", DATA, 16'h0061);
        rd("ovf_1", DATA, 16'h0062);
        rd("ovf_2", DATA, 16'h0063);
        rd("ovf_3", DATA, 16'h0064);
        rd("ovf_empty", DATA, 16'h0000);
        rd("ovf_status", STAT, 16'h0000);
        key(1'b0, 8'h1C, 1'b0);
        key(1'b0, 8'h32, 1'b0);
        key(1'b0, 8'h21, 1'b0);
        key(1'b0, 8'h23, 1'b0);
        key(1'b0, 8'h24, 1'b0);
        check("ovf_held_one", {15'b0, key_down}, 16'h0001);
        key(1'b0, 8'h2B, 1'b0);
        check("ovf_held_none", {15'b0, key_down}, 16'h0000);

        // High-byte-only write leaves the IRQ disable bit alone
        wr("wr_hi", STAT, 2'b10, 16'h0040);
        rd("wr_hi_status", STAT, 16'h0000);

        // IRQ disable, re-enable, acknowledge
        wr("dis", STAT, 2'b01, 16'h0040);
        key(1'b0, 8'h1C, 1'b1);
        rd("dis_status", STAT, 16'h00C0);
        check("dis_req60", {15'b0, virq_req60}, 16'h0000);
        wr("en", STAT, 2'b01, 16'h0000);
        check("en_req60", {15'b0, virq_req60}, 16'h0001);
        virq_ack60 = 1'b1;
        tick();
        virq_ack60 = 1'b0;
        tick();
        check("taken_req60", {15'b0, virq_req60}, 16'h0000);
        rd("taken_data", DATA, 16'h0061);
        key(1'b0, 8'h1C, 1'b0);

        // STOP and reset keys
        key(1'b0, 8'h78, 1'b1);
        check("stop_on", {15'b0, key_stop}, 16'h0001);
        rd("stop_no_push", STAT, 16'h0000);
        key(1'b0, 8'h78, 1'b0);
        check("stop_off", {15'b0, key_stop}, 16'h0000);
        key(1'b0, 8'h07, 1'b1);
        check("rkey_on", {15'b0, key_reset}, 16'h0001);
        key(1'b0, 8'h07, 1'b0);
        check("rkey_off", {15'b0, key_reset}, 16'h0000);

        // F9 pulse
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h01};
        tick();
        check("color_pulse", {15'b0, key_color}, 16'h0001);
        tick();
        check("color_end", {15'b0, key_color}, 16'h0000);
        key(1'b0, 8'h01, 1'b0);

        // Reset during a read with three codes queued
        key(1'b0, 8'h1C, 1'b1);
        key(1'b0, 8'h32, 1'b1);
        key(1'b0, 8'h21, 1'b1);
        bus.bus_sync = 1'b1;
        bus.bus_addr = DATA;
        bus.bus_we   = 1'b0;
        bus.bus_stb  = 1'b1;
        tick();
        check("mid_ack", {15'b0, bus.bus_ack}, 16'h0001);
        check("mid_dout", bus.bus_dout, 16'h0061);
        reset = 1'b1;
        tick();
        check("mid_rst_ack", {15'b0, bus.bus_ack}, 16'h0000);
        reset = 1'b0;
        tick();
        bus.bus_stb  = 1'b0;
        bus.bus_sync = 1'b0;
        tick();
        check("mid_rst_req60", {15'b0, virq_req60}, 16'h0000);
        check("mid_rst_key_down", {15'b0, key_down}, 16'h0000);
        rd("mid_rst_status", STAT, 16'h0000);
        rd("mid_rst_data", DATA, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_bk_keyboard.md
Name: ps2_bk_keyboard

Overview:
- Keyboard controller feeding the VM1 bus.
- Translates PS/2 key events from hps_io into BK-style 7-bit key codes and buffers them in a 4-entry FIFO.
- Exposes keyboard status register 177660 and data register 177662 to the CPU.
- Raises vectored-interrupt requests (060 / 274) toward vic_wb and drives the STOP, RESET, colour/BW and key-held lines used by the top level.

Parameters:
- FIFO_DEPTH, 4, code FIFO entries; power of two; 2..16.
- STOP_SCAN, 8'h78, PS/2 scancode for STOP (F11).
- RESET_SCAN, 8'h07, PS/2 scancode for reset (F12).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
- bus_sync  in  1  address-valid qualifier.
- bus_addr  in  16  byte address.
- bus_we  in  1  write cycle.
- bus_wtbt  in  2  byte enables [1] high, [0] low.
- bus_stb  in  1  data strobe (read or write).
- bus_din  in  16  CPU write data.
- bus_dout  out  16  read data; zero when not selected.
- bus_ack  out  1  reply.
- virq_req60  out  1  request, vector 060.
- virq_req274  out  1  request, vector 274.
- virq_ack60  in  1  vector 060 taken.
- virq_ack274  in  1  vector 274 taken.
- key_down  out  1  any non-modifier key held.
- key_stop  out  1  STOP key held.
- key_reset  out  1  reset key held.
- key_color  out  1  one-cycle pulse on F9 press.
- key_bw  out  1  one-cycle pulse on F10 press.
- ps2_caps_led  out  1  caps-lock state.

Behaviour:
Reset:
- Applies synchronously, including mid-event or mid-bus-cycle.
- Clears the FIFO, modifiers, held counter, IRQ-disable bit (bit 6 = 0), all outputs and the caps state.
- Samples the current ps2_key[10] into the strobe-edge register so no event is decoded on reset release.

Event capture:
- An event is a change of ps2_key[10] versus its registered copy; one event is processed per cycle.
- Modifier scancodes update state only:
  - Shift 12/59.
  - Ctrl 14.
  - Alt 11 (AR2).
  - Caps 58: toggles caps on press only.
- STOP_SCAN and RESET_SCAN drive key_stop / key_reset as level = pressed.
- held counter (3 bits):
  - +1 on non-modifier press, saturating at 7.
  - -1 on release, floored at 0.
  - key_down = (held != 0).

Translation (press only, registered, 1 cycle):
- Letters A-Z → 0x41..0x5A when (shift XOR caps) = 1, else 0x61..0x7A.
- Digits 1-9, 0 → 0x31..0x39, 0x30.
- Space 0x20, Enter 0x0A, Backspace 0x18, Tab 0x09.
- Arrows: Left 0x08, Right 0x19, Up 0x1A, Down 0x1B (all extended).
- Ctrl held: code = code & 0x1F.
- Unmapped scancodes produce no push.

FIFO:
- Entry is {ar2, code[6:0]}; ar2 is the Alt state at press time.
- Push when not full. When full, the new code is dropped; existing entries are kept.

Registers:
- Select = bus_sync & bus_addr[15:1] == 177660>>1 (status) or 177662>>1 (data).
- Status read: bit 7 = FIFO non-empty, bit 6 = IRQ disable, others 0.
- Data read: {9'b0, head code}; returns 0 when empty.
- Status write: updates bit 6 from bus_din[6] only if bus_wtbt[0]. Data writes are ignored.
- Data read pops the head on the rising edge of bus_stb. A simultaneous push and pop are both performed.
- bus_ack = 1 the cycle after bus_stb rises with a select, held until bus_stb falls. It is 0 with no select.
- bus_dout is registered together with bus_ack and is stable while bus_ack = 1.

Interrupts:
- req = FIFO non-empty & !bit 6 & !pending_taken.
- Request goes to req274 if head.ar2, else req60.
- virq_ack* sets pending_taken. The next pop clears pending_taken.
- Setting bit 6 drops both requests the next cycle.

Test Plan:
- Reset → status reads 0x0000, data reads 0x0000, no requests, key_down = 0, ps2_caps_led = 0.
- Press "A" (1C), no modifiers → status 0x0080, virq_req60 = 1; data read returns 0x0061; status then reads 0x0000 and the request drops.
- Shift+A, then Caps toggle and Shift+A → codes 0x41 then 0x61; Ctrl+A → 0x01; Alt+Enter → 0x0A on virq_req274.
- Six presses with no reads → 4 codes read back in order, 5th and 6th lost; key_down stays 1 until all six are released.
- Write status 0x0040, press key → status 0x00C0, no request; write 0x0000 → virq_req60 asserts next cycle.
- F11 press/release → key_stop 1/0 and no FIFO push.
- F9 press → single-cycle key_color.
- Reset asserted with 3 queued codes and a bus read in progress → FIFO empties, bus_ack drops the next cycle.
